// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
// State encoding, bytes per instruction and word-address shift.
package inst_loader_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    LEN_HI = S_LEN_HI,
    LEN_LO = S_LEN_LO,
    DATA   = S_DATA,
    WRITE  = S_WRITE,
    CHECK  = S_CHECK,
    DONE   = S_DONE,
    ERR    = S_ERR
  } state_t;

  localparam int INST_BYTES = 4;
  localparam int ADDR_SHIFT = 2;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Big-endian 4-byte word assembler with running XOR checksum.
// Ports: clr, shift, byte_in in; word_full, word, checksum out.
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word,
  output logic [7:0]  checksum
);

  logic [1:0] cnt;

  // High when the next shifted byte completes a word.
  assign word_full = (cnt == 2'(INST_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      word     <= '0;
      checksum <= '0;
    end else if (clr) begin
      cnt      <= '0;
      checksum <= '0;
    end else if (shift) begin
      cnt      <= cnt + 2'd1;
      word     <= {word[23:0], byte_in};
      checksum <= checksum ^ byte_in;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: frames a byte stream into instruction-memory writes.
// Ports: start/byte stream in; wr_* mem port, cpu_hold/done/error out.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  state_t            state, state_n;
  logic [7:0]        n_hi;
  logic [15:0]       n_len;
  logic [15:0]       n_new;
  logic [ADDR_W-1:0] word_idx;
  logic [16:0]       idx_inc;
  logic              acc;
  logic              load;
  logic              last;
  logic              word_full;
  logic [31:0]       pk_word;
  logic [7:0]        checksum;

  assign acc     = byte_valid & byte_ready;
  assign n_new   = {n_hi, byte_in};
  assign idx_inc = 17'(word_idx) + 17'd1;
  assign last    = (idx_inc == {1'b0, n_len});
  assign load    = start &
                   ((state == IDLE) | (state == DONE) | (state == ERR));

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (load),
    .shift     (acc & (state == DATA)),
    .byte_in   (byte_in),
    .word_full (word_full),
    .word      (pk_word),
    .checksum  (checksum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_n = LEN_HI;
      LEN_HI: if (acc) state_n = LEN_LO;
      LEN_LO: if (acc) begin
        if ({1'b0, n_new} > MAXW) state_n = ERR;
        else if (n_new == 16'd0)  state_n = CHECK;
        else                      state_n = DATA;
      end
      DATA:  if (acc && word_full) state_n = WRITE;
      WRITE: state_n = last ? CHECK : DATA;
      CHECK: if (acc) state_n = (byte_in == checksum) ? DONE : ERR;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready   <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      word_idx     <= '0;
      n_hi         <= '0;
      n_len        <= '0;
    end else begin
      byte_ready <= (state_n == LEN_HI) | (state_n == LEN_LO) |
                    (state_n == DATA)   | (state_n == CHECK);
      wr_en      <= (state_n == WRITE);
      cpu_hold   <= (state_n != DONE);
      done       <= (state_n == DONE);
      error      <= (state_n == ERR);
      if (state_n == WRITE) begin
        wr_addr <= 32'(word_idx) << ADDR_SHIFT;
        // The 4th byte lands in the packer on this same edge.
        wr_data <= {pk_word[23:0], byte_in};
      end
      if (state == LEN_HI && acc) n_hi <= byte_in;
      if (state == LEN_LO && acc) n_len <= n_new;
      if (load) begin
        words_loaded <= '0;
        word_idx     <= '0;
      end else if (state == WRITE) begin
        words_loaded <= words_loaded + 1'b1;
        if (!last) word_idx <= word_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader.
// Table-driven loads with random data checked against a stream parser.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  inst_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  int          exp_words;

  typedef struct {
    int nw;
    int lenf;
    bit badck;
    bit bp;
    int st;
    bit d;
    bit e;
  } vec_t;

  vec_t vt[9];

  always @(negedge clk)
    if (rst_n && wr_en) begin
      wq_a.push_back(wr_addr);
      wq_d.push_back(wr_data);
    end

  initial begin
    #2ms;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: parse the stream by its framing rules.
  task automatic model();
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_a.delete();
    exp_d.delete();
    n = {stream[0], stream[1]};
    x = '0;
    if (n > 256) begin
      exp_words = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = '0;
        for (int b = 0; b < 4; b++) begin
          w = (w << 8) | 32'(stream[2 + 4*i + b]);
          x = x ^ stream[2 + 4*i + b];
        end
        exp_a.push_back(32'(i * 4));
        exp_d.push_back(w);
      end
      exp_words = n;
    end
  endtask

  task automatic drive(bit bp, int st);
    int i = 0;
    int cyc = 0;
    bit pulsed = 0;
    bit took;
    while (i < stream.size()) begin
      @(negedge clk);
      start = (i == st) && !pulsed;
      if (start) pulsed = 1;
      byte_in = stream[i];
      byte_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      took = byte_valid && byte_ready;
      @(posedge clk);
      if (took) i++;
      cyc++;
      if (cyc > 10000) begin
        chk("byte_timeout", 32'(i), 32'(stream.size()));
        break;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_load(bit bp, int st, bit ed, bit ee);
    model();
    wq_a.delete();
    wq_d.delete();
    @(negedge clk);
    start = 1'b1;
    byte_valid = 1'b1;
    byte_in = stream[0];
    @(posedge clk);
    drive(bp, st);
    repeat (4) @(negedge clk);
    chk("wr_count", 32'(wq_a.size()), 32'(exp_a.size()));
    for (int k = 0; k < wq_a.size() && k < exp_a.size(); k++) begin
      chk($sformatf("wr_addr[%0d]", k), wq_a[k], exp_a[k]);
      chk($sformatf("wr_data[%0d]", k), wq_d[k], exp_d[k]);
    end
    chk("done", 32'(done), 32'(ed));
    chk("error", 32'(error), 32'(ee));
    chk("cpu_hold", 32'(cpu_hold), 32'(!ed));
    chk("words_loaded", 32'(words_loaded), 32'(exp_words));
    chk("ready_idle", 32'(byte_ready), 32'd0);
    chk("wr_en_idle", 32'(wr_en), 32'd0);
  endtask

  task automatic build(vec_t v);
    int lenf;
    logic [7:0] x;
    logic [7:0] b;
    stream.delete();
    lenf = (v.lenf >= 0) ? v.lenf : v.nw;
    stream.push_back(8'(lenf >> 8));
    stream.push_back(8'(lenf));
    if (lenf <= 256) begin
      x = '0;
      for (int i = 0; i < 4 * lenf; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        stream.push_back(b);
      end
      if (v.badck) x = x ^ 8'($urandom_range(1, 255));
      stream.push_back(x);
    end
  endtask

  task automatic happy_stream();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'hAC, 8'h09, 8'h00, 8'h04, 8'h8C};
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    vt[0] = '{3,    -1, 0, 0, -1, 1, 0};
    vt[1] = '{5,    -1, 0, 1, -1, 1, 0};
    vt[2] = '{2,    -1, 1, 0, -1, 0, 1};
    vt[3] = '{2,    -1, 0, 1, -1, 1, 0};
    vt[4] = '{0, 'h101, 0, 0, -1, 0, 1};
    vt[5] = '{0,     0, 0, 0, -1, 1, 0};
    vt[6] = '{4,    -1, 0, 0,  6, 1, 0};
    vt[7] = '{256,  -1, 0, 1, -1, 1, 0};
    vt[8] = '{1,    -1, 1, 1, -1, 0, 1};

    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of DATA discards the partial word.
    happy_stream();
    stream = stream[0:3];
    wq_a.delete();
    wq_d.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    drive(0, -1);
    rst_n = 1'b0;
    #2;
    chk_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("postrst");
    chk("midrst_writes", 32'(wq_a.size()), 32'd0);

    // Known-good two-word image.
    happy_stream();
    run_load(0, -1, 1, 0);
    if (wq_a.size() >= 2) begin
      chk("hp_addr0", wq_a[0], 32'h0);
      chk("hp_data0", wq_d[0], 32'h20080005);
      chk("hp_addr1", wq_a[1], 32'h4);
      chk("hp_data1", wq_d[1], 32'hAC090004);
    end

    // Same image under random backpressure.
    happy_stream();
    run_load(1, -1, 1, 0);

    // Same image with a bad checksum, then a good relaunch.
    happy_stream();
    stream[10] = 8'h00;
    run_load(0, -1, 0, 1);
    happy_stream();
    run_load(1, -1, 1, 0);

    for (int v = 0; v < 9; v++) begin
      build(vt[v]);
      run_load(vt[v].bp, vt[v].st, vt[v].d, vt[v].e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time program loader: the write side of the instruction memory that the single-cycle datapath reads through ReadAddr/Instruction.
- Takes a byte stream on a valid/ready handshake, frames it as length + big-endian words + checksum, and produces one 32-bit word write per instruction.
- Holds the CPU (PC) in hold until the image is complete and verified.
- Sits beside inst_mem, between the external byte source (UART receiver, testbench) and the memory write port.

Parameters:
- ADDR_W, 8: word-address width; the image holds at most 2**ADDR_W words.
- MAX_WORDS, 256: largest legal word count N; must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  32  byte address of the word, = word_idx*4, bits[1:0]=0.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  1 = PC/datapath frozen.
- done  out  1  image loaded and checksum good.
- error  out  1  length or checksum fault.
- words_loaded  out  ADDR_W+1  count of words written so far.

Behaviour:
- Reset is asynchronous on rst_n low; every register updates on the rising clk edge.
- Reset values:
  - state=IDLE.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - cpu_hold=1, done=0, error=0, words_loaded=0.
  - Checksum accumulator=0.
- All outputs are registered.
- Handshake: a byte transfers on a clk edge where byte_valid && byte_ready. byte_valid may stay high across cycles; each accepting edge consumes exactly one byte.
- Stream format:
  - N_hi, N_lo: 16-bit word count, big-endian.
  - 4*N data bytes: per word, MSB first; the first byte goes to wr_data[31:24].
  - CK: XOR of all 4*N data bytes.
- States:
  - IDLE: byte_ready=0. start -> LEN_HI; clear words_loaded, accumulator, done and error; cpu_hold=1.
  - LEN_HI: byte_ready=1. Accept -> N[15:8], go to LEN_LO.
  - LEN_LO: byte_ready=1. Accept -> N[7:0], then:
    - N > MAX_WORDS: go to ERR.
    - N == 0: go to CHECK.
    - otherwise: go to DATA, with byte_cnt=0 and word_idx=0.
  - DATA: byte_ready=1. Accept -> shift the byte into the word register and XOR it into the accumulator.
    - byte_cnt 0..2: increment byte_cnt.
    - byte_cnt==3: go to WRITE.
  - WRITE: single cycle, byte_ready=0.
    - wr_en=1, wr_addr=word_idx<<2, wr_data=word.
    - word_idx++, words_loaded++.
    - If word_idx+1==N go to CHECK, else go to DATA with byte_cnt=0.
  - CHECK: byte_ready=1. Accept CK.
    - CK == accumulator: go to DONE.
    - Otherwise: go to ERR.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start -> LEN_HI and relaunch (cpu_hold=1, done=0).
  - ERR: error=1, cpu_hold=1, byte_ready=0. Only start or reset leaves ERR; start -> LEN_HI.
- Latency:
  - wr_en asserts on the cycle after the edge that accepts the 4th byte of a word.
  - done asserts on the cycle after the edge that accepts CK.
- wr_en is 0 in every state except WRITE. wr_addr and wr_data keep their last values outside WRITE.
- start is ignored in LEN_HI, LEN_LO, DATA, WRITE and CHECK.
- start arriving on the same cycle as a byte in IDLE: the byte is not consumed, because byte_ready=0.
- rst_n low mid-load: immediate return to reset values; any partial word is discarded and no wr_en is issued.
- Words already written before a fault stay in memory. cpu_hold keeps the CPU frozen.
- word_idx never exceeds MAX_WORDS-1, so wr_addr never wraps.

Decomposition:
- Shared package holds:
  - State encoding (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR) as 3-bit localparams.
  - INST_BYTES=4.
  - Address shift constant 2, consistent with the Shift_L_2 / Add4 word stride.
- One natural sub-module: byte_packer, a 4-byte big-endian shift register with byte_cnt and XOR accumulator. It exposes word_full, word and checksum. The FSM stays in inst_loader.

Test Plan:
- Reset: hold rst_n=0 mid-DATA, then release -> all outputs at reset values, no wr_en, cpu_hold=1, state IDLE.
- Happy path: start, then stream 00 02 | 20 08 00 05 | AC 09 00 04 | 8C -> two writes:
  - wr_en @addr 0x0 data 0x20080005.
  - wr_en @addr 0x4 data 0xAC090004.
  - CK=0x20^0x08^0x00^0x05^0xAC^0x09^0x00^0x04=0x8C -> done=1, cpu_hold=0, words_loaded=2.
- Backpressure: byte_valid toggled randomly over the same stream -> identical writes and done.
  - byte_ready=0 in the WRITE cycle; the byte held during WRITE is consumed on the next edge.
- Checksum fault: same stream with CK=0x00 -> two writes occur, then error=1, done=0, cpu_hold=1. A new start with a good stream -> done=1.
- Length fault: with MAX_WORDS=256, send N=0x0101 -> ERR after LEN_LO, no wr_en ever asserted. N=0x0000 followed by CK=0x00 -> DONE with words_loaded=0.
- Ignored start: pulse start during DATA -> no restart, and the load completes normally.
